// File: rtl/rarp_transmitter_if.sv
// Stream-side bundle for the RARP/ARP transmit framer: header field inputs
// plus the serialised word output with its valid and hold strobes.
interface rarp_transmitter_if;
    logic [15:0] hdr_type;
    logic [15:0] proto_type;
    logic [7:0]  hdr_addr_length;
    logic [7:0]  pro_addr_length;
    logic [15:0] operation;
    logic [47:0] send_hdr_addr;
    logic [31:0] send_ip_addr;
    logic [47:0] target_hdr_addr;
    logic [31:0] target_ip_addr;
    logic [31:0] transmitted_op;
    logic        output_valid;
    logic        input_hold;

    // Upstream producer: supplies fields, observes the stream.
    modport master (
        output hdr_type, proto_type, hdr_addr_length, pro_addr_length, operation,
               send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr,
        input  transmitted_op, output_valid, input_hold
    );

    // Framer side.
    modport slave (
        input  hdr_type, proto_type, hdr_addr_length, pro_addr_length, operation,
               send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr,
        output transmitted_op, output_valid, input_hold
    );
endinterface

// File: rtl/rarp_transmitter.sv
// RARP/ARP transmit framer: captures the 28-byte header in IDLE and emits it
// as seven MSB-first 32-bit words, followed by one idle cycle.
module rarp_transmitter (
    input  logic             clk,
    input  logic             rst_n,
    rarp_transmitter_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] op_q, op_d;
    logic        valid_q, valid_d;
    logic        hold_q, hold_d;

    // w0 is sent straight from the inputs, so htype/ptype never need a copy
    // after capture; they are still latched to keep the capture set complete.
    logic [15:0] htype_q, htype_d;
    logic [15:0] ptype_q, ptype_d;
    logic [7:0]  hlen_q, hlen_d;
    logic [7:0]  plen_q, plen_d;
    logic [15:0] oper_q, oper_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [47:0] tha_q, tha_d;
    logic [31:0] tpa_q, tpa_d;

    logic [31:0] word_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            hold_q  <= 1'b0;
            htype_q <= '0;
            ptype_q <= '0;
            hlen_q  <= '0;
            plen_q  <= '0;
            oper_q  <= '0;
            sha_q   <= '0;
            spa_q   <= '0;
            tha_q   <= '0;
            tpa_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            htype_q <= htype_d;
            ptype_q <= ptype_d;
            hlen_q  <= hlen_d;
            plen_q  <= plen_d;
            oper_q  <= oper_d;
            sha_q   <= sha_d;
            spa_q   <= spa_d;
            tha_q   <= tha_d;
            tpa_q   <= tpa_d;
        end
    end

    always_comb begin
        word_sel = '0;
        case (cnt_q)
            3'd1:    word_sel = {hlen_q, plen_q, oper_q};
            3'd2:    word_sel = sha_q[47:16];
            3'd3:    word_sel = {sha_q[15:0], spa_q[31:16]};
            3'd4:    word_sel = {spa_q[15:0], tha_q[47:32]};
            3'd5:    word_sel = tha_q[31:0];
            3'd6:    word_sel = tpa_q;
            default: word_sel = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        htype_d = htype_q;
        ptype_d = ptype_q;
        hlen_d  = hlen_q;
        plen_d  = plen_q;
        oper_d  = oper_q;
        sha_d   = sha_q;
        spa_d   = spa_q;
        tha_d   = tha_q;
        tpa_d   = tpa_q;

        case (state_q)
            IDLE: begin
                htype_d = bus.hdr_type;
                ptype_d = bus.proto_type;
                hlen_d  = bus.hdr_addr_length;
                plen_d  = bus.pro_addr_length;
                oper_d  = bus.operation;
                sha_d   = bus.send_hdr_addr;
                spa_d   = bus.send_ip_addr;
                tha_d   = bus.target_hdr_addr;
                tpa_d   = bus.target_ip_addr;
                op_d    = {bus.hdr_type, bus.proto_type};
                valid_d = 1'b1;
                hold_d  = 1'b1;
                cnt_d   = 3'd1;
                state_d = SEND;
            end
            SEND: begin
                if (cnt_q == 3'd7) begin
                    op_d    = '0;
                    valid_d = 1'b0;
                    hold_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    op_d  = word_sel;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.transmitted_op = op_q;
    assign bus.output_valid   = valid_q;
    assign bus.input_hold     = hold_q;
endmodule

// File: tb/tb_rarp_transmitter.sv
// Directed bench for rarp_transmitter: word order, input isolation during a
// packet, cadence across packets, async reset mid-packet, opcode pass-through.
module tb_rarp_transmitter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rarp_transmitter_if bus ();

    rarp_transmitter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] pkt_a [7];
    logic [31:0] pkt_b [7];
    logic [31:0] pkt_c [7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [15:0] ht, input logic [15:0] pt,
                              input logic [7:0] hl, input logic [7:0] pl,
                              input logic [15:0] op, input logic [47:0] sha,
                              input logic [31:0] spa, input logic [47:0] tha,
                              input logic [31:0] tpa);
        bus.hdr_type        = ht;
        bus.proto_type      = pt;
        bus.hdr_addr_length = hl;
        bus.pro_addr_length = pl;
        bus.operation       = op;
        bus.send_hdr_addr   = sha;
        bus.send_ip_addr    = spa;
        bus.target_hdr_addr = tha;
        bus.target_ip_addr  = tpa;
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [31:0] exp);
        @(negedge clk);
        chk($sformatf("%s_w%0d_op", tag, idx), bus.transmitted_op, exp);
        chk($sformatf("%s_w%0d_valid", tag, idx), {31'd0, bus.output_valid}, 32'd1);
        chk($sformatf("%s_w%0d_hold", tag, idx), {31'd0, bus.input_hold}, 32'd1);
        $display("%s word%0d op=%h valid=%b hold=%b", tag, idx,
                 bus.transmitted_op, bus.output_valid, bus.input_hold);
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_idle_op"}, bus.transmitted_op, 32'd0);
        chk({tag, "_idle_valid"}, {31'd0, bus.output_valid}, 32'd0);
        chk({tag, "_idle_hold"}, {31'd0, bus.input_hold}, 32'd0);
        $display("%s idle op=%h valid=%b hold=%b", tag,
                 bus.transmitted_op, bus.output_valid, bus.input_hold);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pkt_a = '{32'h00010800, 32'h06040003, 32'h00112233, 32'h4455C0A8,
                  32'h0001AABB, 32'hCCDDEEFF, 32'hC0A80002};
        pkt_b = '{32'h000686DD, 32'h0A100004, 32'hFFFFFFFF, 32'hFFFF0A00,
                  32'h00011234, 32'h56789ABC, 32'h00000000};
        pkt_c = '{32'h00010800, 32'hFF000004, 32'h00112233, 32'h4455C0A8,
                  32'h0001AABB, 32'hCCDDEEFF, 32'hC0A80002};

        rst_n = 1'b0;
        set_fields(16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0003, 48'h001122334455,
                   32'hC0A80001, 48'hAABBCCDDEEFF, 32'hC0A80002);
        repeat (2) @(negedge clk);
        chk("reset_op", bus.transmitted_op, 32'd0);
        chk("reset_valid", {31'd0, bus.output_valid}, 32'd0);
        chk("reset_hold", {31'd0, bus.input_hold}, 32'd0);
        $display("reset op=%h valid=%b hold=%b",
                 bus.transmitted_op, bus.output_valid, bus.input_hold);
        rst_n = 1'b1;

        // Packet A; inputs switch to packet B while word 3 is on the bus.
        for (int i = 0; i < 7; i++) begin
            chk_word("pktA", i, pkt_a[i]);
            if (i == 3)
                set_fields(16'h0006, 16'h86DD, 8'h0A, 8'h10, 16'h0004, 48'hFFFFFFFFFFFF,
                           32'h0A000001, 48'h123456789ABC, 32'h00000000);
        end
        chk_idle("pktA");

        // Three back-to-back packets with constant inputs.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 7; i++)
                chk_word($sformatf("pktB%0d", p), i, pkt_b[i]);
            chk_idle($sformatf("pktB%0d", p));
        end

        // Async reset a couple of ns after word 4 appears, well before the next edge.
        for (int i = 0; i < 5; i++)
            chk_word("pktR", i, pkt_b[i]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_op", bus.transmitted_op, 32'd0);
        chk("async_rst_valid", {31'd0, bus.output_valid}, 32'd0);
        chk("async_rst_hold", {31'd0, bus.input_hold}, 32'd0);
        $display("async reset op=%h valid=%b hold=%b",
                 bus.transmitted_op, bus.output_valid, bus.input_hold);
        set_fields(16'h0001, 16'h0800, 8'hFF, 8'h00, 16'h0004, 48'h001122334455,
                   32'hC0A80001, 48'hAABBCCDDEEFF, 32'hC0A80002);
        @(negedge clk);
        chk("rst_held_valid", {31'd0, bus.output_valid}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            chk_word("pktC", i, pkt_c[i]);
        chk_idle("pktC");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
